// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, fflags bit positions and exponent landmarks.
package fpu_pkg;

  typedef enum logic [2:0] {
    RmRne = 3'b000,
    RmRtz = 3'b001,
    RmRdn = 3'b010,
    RmRup = 3'b011,
    RmRmm = 3'b100
  } rm_e;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_NX = 0;

  localparam logic [7:0] EXP_BIAS     = 8'd127;
  localparam logic [7:0] EXP_U32_OVF  = 8'd159;
  // At or above this exponent every mantissa bit is an integer bit.
  localparam logic [7:0] EXP_INT_EXACT = 8'd150;
  localparam logic [7:0] EXP_MAX      = 8'd255;

endpackage

// File: rtl/fcvt_flag_gen.sv
// Combinational NV/NX flag generation for float -> unsigned 32-bit conversion.
module fcvt_flag_gen
  import fpu_pkg::*;
(
  input  logic [31:0] in_float,
  input  logic [2:0]  in_rm,
  output logic [4:0]  fflags
);

  logic        sign;
  logic [7:0]  exp;
  logic [22:0] man;
  logic        nv;
  logic        nx;

  assign sign = in_float[31];
  assign exp  = in_float[30:23];
  assign man  = in_float[22:0];

  always_comb begin
    nv = 1'b0;
    nx = 1'b0;
    if (exp == EXP_MAX) begin
      nv = 1'b1;
    end else if (exp == 8'd0 && man == 23'd0) begin
      nv = 1'b0;
    end else if (exp < EXP_BIAS) begin
      // Nonzero |x| < 1: negatives are invalid only when they round away from zero.
      if (sign) begin
        case (in_rm)
          RmRdn:   nv = 1'b1;
          RmRne:   nv = (exp == EXP_BIAS - 8'd1) && (man != 23'd0);
          RmRmm:   nv = (exp == EXP_BIAS - 8'd1);
          default: nv = 1'b0;
        endcase
      end
      nx = !nv;
    end else if (sign) begin
      nv = 1'b1;
    end else if (exp >= EXP_U32_OVF) begin
      nv = 1'b1;
    end else if (exp < EXP_INT_EXACT) begin
      nx = (man & (23'h7fffff >> (exp - EXP_BIAS))) != 23'd0;
    end
  end

  always_comb begin
    fflags           = '0;
    fflags[FFLAG_NV] = nv;
    fflags[FFLAG_NX] = nx;
  end

endmodule

// File: rtl/fcvt_wb_stage.sv
// FCVT.WU.S writeback register stage with valid/ready handshake.
// Define FCVT_WB_SKID_EN for a 2-entry skid buffer with registered in_ready.
module fcvt_wb_stage
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  input  logic [2:0]       in_rm,
  input  logic [31:0]      in_int,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_fflags
);

  logic [4:0] in_fflags;
  logic       push;

  fcvt_flag_gen u_flag_gen (
    .in_float (in_float),
    .in_rm    (in_rm),
    .fflags   (in_fflags)
  );

  assign push = in_valid && in_ready;

`ifdef FCVT_WB_SKID_EN

  logic             ready_q;
  logic             skid_valid;
  logic [31:0]      skid_result;
  logic [TAG_W-1:0] skid_tag;
  logic [4:0]       skid_fflags;
  logic             pop;

  assign in_ready = ready_q;
  assign pop      = out_valid && out_ready;

  // The output registers are the FIFO head; the skid register is the second slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_fflags  <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_tag    <= '0;
      skid_fflags <= '0;
    end else if (flush) begin
      ready_q    <= 1'b1;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_result <= skid_result;
        out_tag    <= skid_tag;
        out_fflags <= skid_fflags;
        skid_valid <= push;
        ready_q    <= !push;
        if (push) begin
          skid_result <= in_int;
          skid_tag    <= in_tag;
          skid_fflags <= in_fflags;
        end
      end else begin
        out_valid <= push;
        ready_q   <= 1'b1;
        if (push) begin
          out_result <= in_int;
          out_tag    <= in_tag;
          out_fflags <= in_fflags;
        end
      end
    end else begin
      ready_q <= !(skid_valid || push);
      if (push) begin
        skid_valid  <= 1'b1;
        skid_result <= in_int;
        skid_tag    <= in_tag;
        skid_fflags <= in_fflags;
      end
    end
  end

`else

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_fflags <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (push) begin
        out_result <= in_int;
        out_tag    <= in_tag;
        out_fflags <= in_fflags;
      end
    end
  end

`endif

endmodule

// File: tb/tb_fcvt_wb_stage.sv
// Self-checking bench for fcvt_wb_stage against a queue-based reference model.
module tb_fcvt_wb_stage;

  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_float = '0;
  logic [2:0]       in_rm = '0;
  logic [31:0]      in_int = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_fflags;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic [4:0]       fflags;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  fcvt_wb_stage #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_float   (in_float),
    .in_rm      (in_rm),
    .in_int     (in_int),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_fflags (out_fflags)
  );

  // Flags from the numeric value: split into integer part and remainder, then round.
  function automatic logic [4:0] ref_flags(input logic [31:0] f, input logic [2:0] rm);
    int e;
    int sh;
    longint unsigned m, ip, rem, half, rnd;
    e = int'(f[30:23]);
    if (e == 255) return 5'h10;
    if (f[30:0] == 31'd0) return 5'h00;
    m = 64'(f[22:0]);
    if (e != 0) m = m + (64'd1 << 23);
    else e = 1;
    if (e >= 150) begin
      if (f[31] || e >= 159) return 5'h10;
      return 5'h00;
    end
    sh = 150 - e;
    if (sh > 26) sh = 26;
    ip = m >> sh;
    rem = m & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (!f[31]) return (rem != 0) ? 5'h01 : 5'h00;
    case (rm)
      3'd0:    rnd = ip + ((rem > half || (rem == half && (ip & 64'd1) == 64'd1)) ? 64'd1 : 64'd0);
      3'd2:    rnd = ip + ((rem != 0) ? 64'd1 : 64'd0);
      3'd4:    rnd = ip + ((rem >= half) ? 64'd1 : 64'd0);
      default: rnd = ip;
    endcase
    if (rnd != 0) return 5'h10;
    return (rem != 0) ? 5'h01 : 5'h00;
  endfunction

  function automatic bit model_ready();
`ifdef FCVT_WB_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    logic [22:0] m;
    int sel;
    sel = int'($urandom % 8);
    m = 23'($urandom);
    case (sel)
      0:       e = 8'd255;
      1:       begin e = 8'd0; m = 23'd0; end
      2:       e = 8'd0;
      3:       begin e = 8'd126; if ($urandom % 2 == 0) m = 23'd0; end
      default: e = 8'(110 + $urandom % 60);
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Advance one clock and apply the same cycle's transfers to the model.
  task automatic tick();
    bit push, pop;
    ent_t e;
    push = !reset && !flush && in_valid && model_ready();
    pop = q.size() > 0 && out_ready;
    e.result = in_int;
    e.tag = in_tag;
    e.fflags = ref_flags(in_float, in_rm);
    @(posedge clk);
    #1;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (pop) q.delete(0);
      if (push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_float = 32'h40490fdb;
    in_int = 32'd3;
    in_tag = 5'd9;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== 32'd0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    total++; if (out_fflags !== 5'd0) begin bad++; $display("FAIL reset_out_fflags: got %h want 0", out_fflags); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_convert();
    logic [31:0] vf [10] = '{32'h40490fdb, 32'h4f800000, 32'h41200000, 32'hbf400000, 32'hbf400000,
                             32'hbf400000, 32'hbf000000, 32'hbf000000, 32'h7fc00000, 32'h80000000};
    logic [2:0]  vr [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd4, 3'd0, 3'd0};
    logic [31:0] vi [10] = '{32'd3, 32'hffffffff, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                             32'hffffffff, 32'd0};
    logic [4:0]  vx [10] = '{5'h01, 5'h10, 5'h00, 5'h10, 5'h01, 5'h10, 5'h01, 5'h10, 5'h10, 5'h00};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_float = vf[i];
      in_rm = vr[i];
      in_int = vi[i];
      in_tag = 5'(i);
      out_ready = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL conv_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_result !== vi[i]) begin bad++; $display("FAIL conv_result[%0d]: got %h want %h", i, out_result, vi[i]); end
      total++; if (out_fflags !== vx[i]) begin bad++; $display("FAIL conv_fflags[%0d]: got %h want %h", i, out_fflags, vx[i]); end
      total++; if (out_tag !== 5'(i)) begin bad++; $display("FAIL conv_tag[%0d]: got %0d want %0d", i, out_tag, i); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int next_tag;
    int seen[$];
    bit acc;
    next_tag = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (next_tag <= 3);
      in_tag = 5'(next_tag);
      in_float = 32'h3f800000 + 32'(next_tag << 20);
      in_rm = 3'd0;
      in_int = 32'(next_tag * 100);
      out_ready = (cyc >= 3);
      #1;
      total++;
      if (in_ready !== model_ready()) begin
        bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, in_ready, model_ready());
      end
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        total++; if (out_tag !== 5'd1) begin bad++; $display("FAIL bp_head_tag: got %0d want 1", out_tag); end
      end
      if (out_valid === 1'b1 && out_ready) seen.push_back(int'(out_tag));
      acc = in_valid && model_ready();
      tick();
      if (acc) next_tag++;
    end
    total++;
    if (seen.size() != 3) begin
      bad++; $display("FAIL bp_drain_count: got %0d want 3", seen.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (seen[k] != k + 1) begin bad++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, seen[k], k + 1); end
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_tag = 5'(7 + k);
      in_float = 32'h41200000;
      in_int = 32'd10;
      #1;
      tick();
    end
    flush = 1'b1;
    in_tag = 5'd9;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      in_float = rand_float();
      in_rm = 3'($urandom % 5);
      in_int = $urandom;
      in_tag = 5'($urandom);
      #1;
      total++;
      if (in_ready !== model_ready()) begin
        bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready, model_ready());
      end
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", cyc, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        total++;
        if (out_result !== q[0].result || out_tag !== q[0].tag || out_fflags !== q[0].fflags) begin
          bad++;
          $display("FAIL rnd_data[%0d]: got %h/%0d/%h want %h/%0d/%h", cyc, out_result, out_tag,
                   out_fflags, q[0].result, q[0].tag, q[0].fflags);
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_flush();
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcvt_wb_stage.md
Name: fcvt_wb_stage

Overview:
- Registered output stage directly downstream of the combinational FCVT.WU.S converter.
- Captures the converter's 32-bit unsigned result together with the original float operand, rounding mode and destination tag.
- Computes the IEEE exception flags (NV, NX) and hands result plus flags to the integer writeback path over a valid/ready handshake.
- Decouples the converter's combinational path from writeback timing and backpressure.

Parameters:
- TAG_W, 5, width of destination register tag carried alongside the result.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; drops all held entries
- in_valid  input  1  converter output valid
- in_ready  output  1  stage can accept this cycle
- in_float  input  32  original single-precision operand
- in_rm  input  3  resolved rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
- in_int  input  32  converter result
- in_tag  input  TAG_W  destination register tag
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts
- out_result  output  32  registered integer result
- out_tag  output  TAG_W  registered tag
- out_fflags  output  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF always 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: out_valid=0, out_result=0, out_tag=0, out_fflags=0, all entry valid bits 0. in_ready=1 on the first cycle after reset.
- Transfer rules:
  - An input transfer occurs when in_valid&&in_ready.
  - An output transfer occurs when out_valid&&out_ready.
  - Latency is 1 cycle: data accepted at edge N is visible on outputs after edge N.
- Output stability: while out_valid=1 and out_ready=0, out_result, out_tag and out_fflags hold stable.
- Ordering: strict FIFO; no reordering or dropping except on flush/reset.
- Field decode: exp=in_float[30:23], man=in_float[22:0], sign=in_float[31].
- NV=1 when any of:
  - exp==255 (NaN or infinity);
  - sign=0 and exp>=159 (value >= 2^32);
  - sign=1 and the value rounds to a nonzero magnitude.
- Negative inputs with |x|<1 and x nonzero:
  - RTZ, RUP: rounds to 0, so NX only.
  - RDN: NV.
  - RNE: NV if exp==126 and man!=0 (|x|>0.5); otherwise NX.
  - RMM: NV if exp==126 (|x|>=0.5); otherwise NX.
  - Any other negative with exp>=127: NV.
- NX=1 when NV=0 and any fraction bits are discarded:
  - exp<127 with input nonzero, or
  - 127<=exp<150 with nonzero man bits below the binary point.
- Zero inputs (±0): no flags.
- NV and NX are mutually exclusive.
- out_result = in_int unmodified. The converter already saturates: 0xFFFFFFFF for NaN/+overflow, 0 for negatives.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured.
  - flush has priority over a push in the same cycle; out_valid=0 next cycle.
  - reset has priority over flush.
  - reset mid-transfer discards everything held.

Optional Feature:
- Macro: FCVT_WB_SKID_EN.
- Defined: 2-entry skid buffer.
  - in_ready is driven from a register: 1 when fewer than 2 entries are held.
  - No combinational path from out_ready to in_ready.
  - Sustains 1 transfer/cycle under intermittent backpressure.
- Undefined: single register.
  - in_ready = !out_valid || out_ready (combinational).
  - Same data and flag behaviour, same 1-cycle latency.

Decomposition:
- Shared package (fpu_pkg):
  - rounding-mode enum (RNE..RMM);
  - fflags bit-index constants (FFLAG_NV=4, FFLAG_NX=0);
  - EXP_BIAS=127 and EXP_U32_OVF=159 constants.
- Sub-module fcvt_flag_gen: purely combinational (in_float, in_rm) -> fflags. Reusable for the signed FCVT.W.S stage.
- The top level holds the handshake and storage.

Test Plan:
- 0x40490FDB (3.14159), rm=RNE, in_int=3, out_ready=1 -> next cycle out_valid=1, out_result=3, out_fflags=0x01.
- 0x4F800000 (2^32), in_int=0xFFFFFFFF -> out_fflags=0x10. Also 0x41200000 (10.0), in_int=10 -> out_fflags=0x00.
- 0xBF400000 (-0.75), in_int=0: rm=RNE -> 0x10; rm=RTZ -> 0x01; rm=RDN -> 0x10. Also 0xBF000000 (-0.5): RNE -> 0x01; RMM -> 0x10.
- 0x7FC00000 (NaN) -> out_fflags=0x10 with out_result passed through (0xFFFFFFFF); 0x80000000 (-0) -> out_fflags=0x00.
- Backpressure with skid enabled:
  - stimulus: 3 back-to-back inputs tags 1,2,3; out_ready=0 for 3 cycles, then 1;
  - required: in_ready=0 after 2 entries held, tag 3 held at input;
  - required: outputs drain in order 1,2,3 with no loss and no duplication.
- Flush and reset:
  - flush with 2 entries held -> out_valid=0 next cycle, in_ready=1;
  - reset asserted in the same cycle as a push -> entry discarded and all outputs at reset values.
